c2s_responder: RTL and testbench

- Hardware-side endpoint of the simulator/C packet protocol, in the reverse direction: the C side issues packets and this block executes them in RTL.
- Accepts word-serial request packets {id, fn, data[DATA_SIZE]}, dispatches on fn (setup / call / check_end) and returns word-serial response packets {id, ret, data[DATA_SIZE]}.
- fn=1 (call) performs one access on a simple register bus.
- Sits between the DPI transport shim and the DUT register space.

---
 rtl/c2s_pkg.sv | 31 +++
 rtl/c2s_bus_master.sv | 53 +++++
 rtl/c2s_responder.sv | 186 ++++++++++++++++++
 tb/tb_c2s_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/c2s_pkg.sv
// Shared definitions for the C-to-sim request/response endpoint.
package c2s_pkg;

    localparam int unsigned DATA_SIZE_DEF = 4;

    // Function codes carried in request beat 1
    typedef enum logic [31:0] {
        FN_SETUP     = 32'd0,
        FN_CALL      = 32'd1,
        FN_CHECK_END = 32'd2
    } fn_e;

    // Return codes, two's complement
    localparam logic signed [31:0] RET_OK      = 32'sd0;
    localparam logic signed [31:0] RET_BADID   = -32'sd1;
    localparam logic signed [31:0] RET_NOSETUP = -32'sd2;
    localparam logic signed [31:0] RET_BADFN   = -32'sd3;
    localparam logic signed [31:0] RET_TIMEOUT = -32'sd4;

    typedef enum logic [2:0] {
        RX_ID,
        RX_FN,
        RX_DATA,
        EXEC,
        BUS_WAIT,
        TX_ID,
        TX_RET,
        TX_DATA
    } state_e;

endpackage

// File: rtl/c2s_bus_master.sv
// Single-access register bus master with a bounded wait.
// start latches the access; done/timeout are same-cycle indications while waiting.
module c2s_bus_master #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        done,
    output logic        timeout
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] wait_cnt;

    // Completion takes priority over an expiring wait in the same cycle
    assign done    = bus_valid && bus_ready;
    assign timeout = bus_valid && !bus_ready && (wait_cnt == CntLast);

    // Access request register and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            wait_cnt  <= '0;
        end else if (start) begin
            bus_valid <= 1'b1;
            bus_we    <= we;
            bus_addr  <= addr;
            bus_wdata <= wdata;
            wait_cnt  <= '0;
        end else if (bus_valid) begin
            if (done || timeout) begin
                bus_valid <= 1'b0;
            end else begin
                wait_cnt <= wait_cnt + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/c2s_responder.sv
// Executes word-serial request packets from the C side and returns responses.
// Only bus CALLs leave EXEC for BUS_WAIT; everything else answers directly.
module c2s_responder
    import c2s_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
    parameter int unsigned NUM_ID    = 8,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        end_req,
    output logic        busy
);

    localparam int unsigned CntW = $clog2(DATA_SIZE);
    localparam int unsigned IdW  = (NUM_ID > 1) ? $clog2(NUM_ID) : 1;
    localparam logic [CntW-1:0] LastWord = CntW'(DATA_SIZE - 1);

    state_e          state;
    logic [31:0]     id;
    logic [31:0]     fn;
    logic [CntW-1:0] word_cnt;
    logic [31:0]     ret;
    logic [31:0]     rd_word;
    logic [NUM_ID-1:0] setup;
    logic [31:0]     call_addr;
    logic [31:0]     call_wdata;
    logic            call_we;

    logic            id_ok;
    logic [IdW-1:0]  id_idx;
    logic            call_ok;
    logic            bus_done;
    logic            bus_timeout;

    assign id_ok   = (id < 32'(NUM_ID));
    assign id_idx  = id[IdW-1:0];
    assign call_ok = (state == EXEC) && (fn == FN_CALL) && id_ok && setup[id_idx];

    assign req_ready = (state == RX_ID) || (state == RX_FN) || (state == RX_DATA);
    assign busy      = (state != RX_ID);

    c2s_bus_master #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_master (
        .clk       (clk),
        .rst       (rst),
        .start     (call_ok),
        .we        (call_we),
        .addr      (call_addr),
        .wdata     (call_wdata),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .done      (bus_done),
        .timeout   (bus_timeout)
    );

    // Packet FSM: receive, execute, optionally wait on the bus, transmit
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_ID;
            id         <= '0;
            fn         <= '0;
            word_cnt   <= '0;
            ret        <= '0;
            rd_word    <= '0;
            setup      <= '0;
            call_addr  <= '0;
            call_wdata <= '0;
            call_we    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
        end else begin
            unique case (state)
                RX_ID: begin
                    if (req_valid) begin
                        id    <= req_data;
                        state <= RX_FN;
                    end
                end
                RX_FN: begin
                    if (req_valid) begin
                        fn       <= req_data;
                        word_cnt <= '0;
                        state    <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (req_valid) begin
                        // Only the first three words carry meaning; the rest are drained
                        if (word_cnt == CntW'(0)) call_addr  <= req_data;
                        if (word_cnt == CntW'(1)) call_wdata <= req_data;
                        if (word_cnt == CntW'(2)) call_we    <= req_data[0];
                        if (word_cnt == LastWord) begin
                            state <= EXEC;
                        end else begin
                            word_cnt <= word_cnt + CntW'(1);
                        end
                    end
                end
                EXEC: begin
                    rd_word <= '0;
                    case (fn)
                        FN_SETUP: begin
                            if (id_ok) begin
                                setup[id_idx] <= 1'b1;
                                ret           <= RET_OK;
                            end else begin
                                ret <= RET_BADID;
                            end
                        end
                        FN_CALL: begin
                            if (!call_ok) ret <= RET_NOSETUP;
                        end
                        FN_CHECK_END: ret <= end_req ? 32'd1 : RET_OK;
                        default:      ret <= RET_BADFN;
                    endcase
                    if (call_ok) begin
                        state <= BUS_WAIT;
                    end else begin
                        state     <= TX_ID;
                        rsp_valid <= 1'b1;
                        rsp_data  <= id;
                    end
                end
                BUS_WAIT: begin
                    if (bus_done) begin
                        ret <= RET_OK;
                        if (!call_we) rd_word <= bus_rdata;
                        state     <= TX_ID;
                        rsp_valid <= 1'b1;
                        rsp_data  <= id;
                    end else if (bus_timeout) begin
                        ret       <= RET_TIMEOUT;
                        rd_word   <= '0;
                        state     <= TX_ID;
                        rsp_valid <= 1'b1;
                        rsp_data  <= id;
                    end
                end
                TX_ID: begin
                    if (rsp_ready) begin
                        rsp_data <= ret;
                        state    <= TX_RET;
                    end
                end
                TX_RET: begin
                    if (rsp_ready) begin
                        rsp_data <= rd_word;
                        word_cnt <= '0;
                        state    <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (rsp_ready) begin
                        rsp_data <= '0;
                        if (word_cnt == LastWord) begin
                            rsp_valid <= 1'b0;
                            state     <= RX_ID;
                        end else begin
                            word_cnt <= word_cnt + CntW'(1);
                        end
                    end
                end
                default: state <= RX_ID;
            endcase
        end
    end

endmodule

// File: tb/tb_c2s_responder.sv
// Directed bench with a response scoreboard and a small bus slave.
module tb_c2s_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        end_req = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    bit bus_forbid = 1'b0;

    always #5 clk = ~clk;

    c2s_responder #(
        .DATA_SIZE (4),
        .NUM_ID    (8),
        .TIMEOUT   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .end_req   (end_req),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        int n;
        repeat (gap) tick();
        req_valid = 1'b1;
        req_data  = w;
        n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_ready_wait: got req_ready=0 expected 1 within 200 cycles");
        end
        tick();
        req_valid = 1'b0;
        req_data  = '0;
    endtask

    // Push the expected response (if any) and then drive the request packet
    task automatic do_req(input logic [31:0] id, input logic [31:0] fn, input logic [31:0] d0,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] ret,
                          input logic [31:0] w0, input bit push, input bit gaps);
        logic [31:0] w [6];
        if (push) begin
            exp_q.push_back(id);
            exp_q.push_back(ret);
            exp_q.push_back(w0);
            for (int i = 0; i < 3; i++) exp_q.push_back(32'd0);
        end
        w = '{id, fn, d0, d1, d2, 32'd0};
        for (int i = 0; i < 6; i++) send_word(w[i], gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic wait_bus_valid();
        int n = 0;
        while (!bus_valid && n < 50) begin
            tick();
            n++;
        end
        chk("bus_valid_up", {31'd0, bus_valid}, 32'd1);
    endtask

    task automatic serve_bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input int delay, input logic [31:0] rdata);
        wait_bus_valid();
        chk("bus_we", {31'd0, bus_we}, {31'd0, we});
        chk("bus_addr", bus_addr, addr);
        chk("bus_wdata", bus_wdata, wdata);
        for (int i = 0; i < delay; i++) begin
            tick();
            chk("bus_hold_valid", {31'd0, bus_valid}, 32'd1);
            chk("bus_hold_addr", bus_addr, addr);
            chk("bus_hold_wdata", bus_wdata, wdata);
        end
        bus_ready = 1'b1;
        bus_rdata = rdata;
        tick();
        bus_ready = 1'b0;
        bus_rdata = '0;
        chk("bus_valid_drop", {31'd0, bus_valid}, 32'd0);
        chk("rsp_after_bus", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 1000) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || busy) begin
            errors++;
            $display("FAIL idle_wait: got %0d words pending busy=%0d expected 0 pending busy=0",
                     exp_q.size(), busy);
        end
    endtask

    // Scoreboard monitor: pops one expected word per response handshake
    initial begin
        logic        stall_prev;
        logic [31:0] held;
        logic [31:0] e;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (stall_prev) begin
                chk("rsp_stall_valid", {31'd0, rsp_valid}, 32'd1);
                chk("rsp_stall_data", rsp_data, held);
            end
            if (rsp_valid && rsp_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got %h expected no word", rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_word", rsp_data, e);
                end
            end
            stall_prev = rsp_valid && !rsp_ready && !rst;
            held = rsp_data;
            if (bus_forbid) chk("bus_forbidden", {31'd0, bus_valid}, 32'd0);
        end
    end

    initial begin
        int n;
        repeat (3) tick();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();

        // Setup id 3 with latency check: EXEC cycle then first response word
        do_req(32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("lat_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("lat_exec_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("lat_first_rsp", {31'd0, rsp_valid}, 32'd1);
        wait_idle();

        // Setup of an out-of-range id
        do_req(32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        wait_idle();

        // Write call, bus_ready after 5 cycles; rdata must not leak into data[0]
        do_req(32'd3, 32'd1, 32'h100, 32'hDEAD_BEEF, 32'd1, 32'd0, 32'd0, 1'b1, 1'b0);
        serve_bus(1'b1, 32'h100, 32'hDEAD_BEEF, 5, 32'hAAAA_5555);
        wait_idle();

        // Read call with request gaps and a 20-cycle stall on data[0]
        do_req(32'd3, 32'd1, 32'h200, 32'd0, 32'd0, 32'd0, 32'h1234_5678, 1'b1, 1'b1);
        serve_bus(1'b0, 32'h200, 32'd0, 2, 32'h1234_5678);
        tick();
        tick();
        rsp_ready = 1'b0;
        repeat (20) tick();
        rsp_ready = 1'b1;
        wait_idle();

        // Calls to an un-setup id and an out-of-range id never touch the bus
        bus_forbid = 1'b1;
        do_req(32'd5, 32'd1, 32'h200, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'd0, 1'b1, 1'b0);
        wait_idle();
        do_req(32'd9, 32'd1, 32'h200, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'd0, 1'b1, 1'b0);
        wait_idle();
        bus_forbid = 1'b0;

        // Read timeout: bus_valid held 16 cycles, data[0] forced to 0
        do_req(32'd3, 32'd1, 32'h300, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd0, 1'b1, 1'b0);
        wait_bus_valid();
        bus_rdata = 32'hBAD0_BAD0;
        n = 0;
        while (bus_valid && n < 100) begin
            tick();
            n++;
        end
        bus_rdata = '0;
        chk("timeout_cycles", 32'(n), 32'd16);
        chk("timeout_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        wait_idle();

        // check_end both ways, then an unknown function
        end_req = 1'b0;
        do_req(32'd1, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        wait_idle();
        end_req = 1'b1;
        do_req(32'd1, 32'd2, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 1'b1, 1'b1);
        wait_idle();
        end_req = 1'b0;
        do_req(32'd2, 32'd7, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFD, 32'd0, 1'b1, 1'b0);
        wait_idle();

        // Reset during BUS_WAIT drops everything, including setup state
        do_req(32'd3, 32'd1, 32'h400, 32'd5, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
        wait_bus_valid();
        rst = 1'b1;
        tick();
        chk("midrst_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();
        bus_forbid = 1'b1;
        do_req(32'd3, 32'd1, 32'h400, 32'd5, 32'd1, 32'hFFFF_FFFE, 32'd0, 1'b1, 1'b0);
        wait_idle();
        bus_forbid = 1'b0;

        repeat (3) tick();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
